// File: rtl/spi_upcounter_pkg.sv
// Shared types and constants for the SPI up-counter link.
package spi_upcounter_pkg;

    // Receiver FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RX      = 2'd1,
        WAIT_CS = 2'd2
    } spi_slave_state_t;

    // Bits per SPI frame; the top two bits are padding around the count.
    localparam int FRAME_BITS = 16;

    // Defaults shared with the master / control-unit side.
    localparam int DATA_W    = 14;
    localparam int MAX_VALUE = 9999;

endpackage

// File: rtl/spi_upcounter_slave_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin with registered
// single-cycle rise/fall pulses of the synchronized level.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic prev_q, prev_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Next-state: shift chain and compare synced level with its previous value.
    always_comb begin
        sync_d[0] = i_async;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
        fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
    end

    // Registers; a pin held low through reset produces no fall pulse after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign o_rise = rise_q;
    assign o_fall = fall_q;

endmodule

// File: rtl/spi_upcounter_slave.sv
// SPI mode-0 slave: receives 16-bit frames carrying a bounded count,
// commits legal values with a valid strobe, flags short/out-of-range
// frames, and echoes the last committed count on MISO.
module spi_upcounter_slave #(
    parameter int DATA_W      = spi_upcounter_pkg::DATA_W,
    parameter int MAX_VALUE   = spi_upcounter_pkg::MAX_VALUE,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_sclk,
    input  logic              i_mosi,
    input  logic              i_cs_n,
    output logic              o_miso,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_frame_err,
    output logic              o_busy
);
    import spi_upcounter_pkg::*;

    logic sclk_rise, sclk_fall;
    logic cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
    logic mosi_sync;

    spi_slave_state_t state_q, state_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] rx_q, rx_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [DATA_W-1:0]     value;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk    (clk),
        .rst_n  (reset),
        .i_async(i_sclk),
        .o_rise (sclk_rise),
        .o_fall (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk    (clk),
        .rst_n  (reset),
        .i_async(i_cs_n),
        .o_rise (cs_rise),
        .o_fall (cs_fall)
    );

    // MOSI synchronizer, same depth as the sclk path so data lines up with the edge pulses.
    always_comb begin
        mosi_d[0] = i_mosi;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            mosi_d[i] = mosi_q[i-1];
        end
    end

    assign mosi_sync = mosi_q[SYNC_STAGES-1];

    // Frame FSM: next state, shift registers, commit/reject strobes.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        value     = '0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = RX;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                    tx_d      = {{(FRAME_BITS-DATA_W){1'b0}}, data_q};
                end
            end
            RX: begin
                if (sclk_fall) begin
                    tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
                end
                if (sclk_rise && bit_cnt_q == 5'(FRAME_BITS-1)) begin
                    // Last bit: decide commit or reject; a coincident cs rise is not an error.
                    rx_d      = {rx_q[FRAME_BITS-2:0], mosi_sync};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    value     = rx_d[DATA_W-1:0];
                    if (32'(value) <= MAX_VALUE) begin
                        data_d  = value;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = cs_rise ? IDLE : WAIT_CS;
                end else if (cs_rise) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    rx_d      = {rx_q[FRAME_BITS-2:0], mosi_sync};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end
            WAIT_CS: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any frame without a strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mosi_q    <= '0;
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            mosi_q    <= mosi_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign o_miso      = (state_q != IDLE) ? tx_q[FRAME_BITS-1] : 1'b0;
    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = err_q;
    assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_upcounter_slave.sv
// Scoreboard bench for spi_upcounter_slave: an SPI master task drives
// frames, a reference model predicts commit/reject events into a queue,
// and a monitor pops and compares whenever the DUT strobes.
module tb_spi_upcounter_slave;

    localparam int DW   = 14;
    localparam int MAXV = 9999;

    logic          clk;
    logic          reset;
    logic          sclk;
    logic          mosi;
    logic          cs_n;
    logic          miso;
    logic [DW-1:0] data;
    logic          valid;
    logic          frame_err;
    logic          busy;

    typedef struct {
        bit       is_err;
        int       value;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   model_data = 0;

    spi_upcounter_slave #(.DATA_W(DW), .MAX_VALUE(MAXV), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_sclk     (sclk),
        .i_mosi     (mosi),
        .i_cs_n     (cs_n),
        .o_miso     (miso),
        .o_data     (data),
        .o_valid    (valid),
        .o_frame_err(frame_err),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest predicted event.
    always @(negedge clk) begin
        if (reset && (valid || frame_err)) begin
            if (valid && frame_err) begin
                chk("valid_and_err_together", 1, 0);
            end else if (exp_q.size() == 0) begin
                chk("unexpected_strobe", valid ? 1 : 2, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("strobe_kind_is_err", int'(frame_err), int'(e.is_err));
                if (valid) chk("commit_data", int'(data), e.value);
                else       chk("reject_keeps_data", int'(data), e.value);
            end
        end
    end

    // Reference model: predict the outcome of a frame from its bit count and first 16 bits.
    task automatic predict(input logic [31:0] bits, input int nbits);
        exp_t e;
        logic [31:0] first16;
        int v;
        if (nbits < 16) begin
            e.is_err = 1'b1;
            e.value  = model_data;
        end else begin
            first16 = bits >> (nbits - 16);
            v = int'(first16 % 32'd16384);
            if (v <= MAXV) begin
                e.is_err   = 1'b0;
                e.value    = v;
                model_data = v;
            end else begin
                e.is_err = 1'b1;
                e.value  = model_data;
            end
        end
        exp_q.push_back(e);
    endtask

    // SPI mode-0 master, sclk = clk/10; optional reset pulse at bit index reset_at.
    task automatic send_frame(input logic [31:0] bits, input int nbits, input int reset_at);
        logic [15:0] echo;
        bit check_miso;
        echo = 16'(model_data);
        check_miso = (reset_at < 0);
        if (reset_at < 0) predict(bits, nbits);
        @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == reset_at) begin
                reset = 1'b0;
                #1;
                chk("rst_mid_data", int'(data), 0);
                chk("rst_mid_valid", int'(valid), 0);
                chk("rst_mid_err", int'(frame_err), 0);
                chk("rst_mid_miso", int'(miso), 0);
                chk("rst_mid_busy", int'(busy), 0);
                model_data = 0;
                repeat (3) @(negedge clk);
                reset = 1'b1;
            end
            mosi = bits[nbits-1-i];
            repeat (5) @(negedge clk);
            if (check_miso && i < 16) chk($sformatf("miso_bit%0d", i), int'(miso), int'(echo[15-i]));
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (5) @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (12) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_miso", int'(miso), 0);
    endtask

    // Bounded wait for the scoreboard to drain, then check the held count.
    task automatic settle(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_events_seen"}, exp_q.size(), 0);
        exp_q.delete();
        chk({name, "_data"}, int'(data), model_data);
    endtask

    initial begin
        logic [31:0] bits;
        int nb;
        reset = 1'b0;
        sclk  = 1'b0;
        mosi  = 1'b0;
        cs_n  = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data", int'(data), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_err", int'(frame_err), 0);
        chk("reset_miso", int'(miso), 0);
        chk("reset_busy", int'(busy), 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        send_frame(32'h04D2, 16, -1);            settle("f1234");
        send_frame(32'h0000, 16, -1);            settle("f0");
        send_frame(32'h2710, 16, -1);            settle("f10000");
        send_frame(32'h04D2, 16, -1);            settle("f1234b");
        send_frame(32'h0155, 9, -1);             settle("short9");
        send_frame(32'h0005, 16, -1);            settle("f5");
        send_frame({12'h0, 16'h270F, 4'hA}, 20, -1); settle("long20");
        send_frame(32'hC123, 16, -1);            settle("topbits");

        // Reset during bit 8; cs_n stays low, so the remaining bits must be ignored.
        send_frame(32'h0042, 16, 8);             settle("rst_frame");
        send_frame(32'h0005, 16, -1);            settle("after_rst");

        for (int k = 0; k < 20; k++) begin
            case ($urandom_range(0, 5))
                0:       nb = $urandom_range(1, 15);
                1:       nb = $urandom_range(17, 24);
                default: nb = 16;
            endcase
            bits = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                bits = bits & ~(32'h3FFF << (nb - 16 >= 0 ? nb - 16 : 0));
                bits = bits | (32'($urandom_range(0, MAXV)) << (nb >= 16 ? nb - 16 : 0));
            end
            send_frame(bits, nb, -1);
            settle($sformatf("rand%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
